// File: rtl/led_anim_pkg.sv
// Shared types and constants for the LED animation path: mode width, mode codes,
// button FSM state encoding and the mode wrap helper.
package led_anim_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_0 = 2'd0;
    localparam logic [MODE_W-1:0] MODE_1 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_2 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_3 = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } btn_state_t;

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                   input int num_modes);
        return (int'(cur) == num_modes - 1) ? MODE_0 : MODE_W'(int'(cur) + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter-based debounce FSM for a push button.
// With LED_MODE_LONG_PRESS_EN the synchronised level is also exported.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | debounced level low; cnt counts consecutive high samples
//   ST_HELD | debounced level high; cnt counts consecutive low samples
module btn_debounce
    import led_anim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
`ifdef LED_MODE_LONG_PRESS_EN
    output logic btn_s,
`endif
    output logic btn_held,
    output logic press_acc
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifndef LED_MODE_LONG_PRESS_EN
    logic btn_s;
`endif
    logic             sync_0;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_0   <= 1'b0;
            btn_s    <= 1'b0;
            state    <= ST_IDLE;
            cnt      <= '0;
            btn_held <= 1'b0;
        end else begin
            sync_0   <= btn_in;
            btn_s    <= sync_0;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_held <= (state_nxt == ST_HELD);
        end
    end

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!btn_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    press_acc = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (btn_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// Push-button animation mode selector: each debounced press advances the mode with wrap.
// Optional long-press return to mode 0 is enabled by defining LED_MODE_LONG_PRESS_EN.
module led_mode_ctrl
    import led_anim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int NUM_MODES         = 4,
    parameter int LONG_PRESS_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              btn_held,
    output logic              long_press
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $fatal(1, "led_mode_ctrl: DEBOUNCE_CYCLES must be at least 2");
    end
    if (NUM_MODES < 2 || NUM_MODES > 2**MODE_W) begin : g_bad_modes
        $fatal(1, "led_mode_ctrl: NUM_MODES out of range");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
        $fatal(1, "led_mode_ctrl: LONG_PRESS_CYCLES must be at least 1");
    end

    logic press_acc;
    logic long_fire;
`ifdef LED_MODE_LONG_PRESS_EN
    logic btn_s;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
`ifdef LED_MODE_LONG_PRESS_EN
        .btn_s     (btn_s),
`endif
        .btn_held  (btn_held),
        .press_acc (press_acc)
    );

`ifdef LED_MODE_LONG_PRESS_EN
    localparam int                LCNT_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_FIRE = LCNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_SAT  = LCNT_W'(LONG_PRESS_CYCLES);

    logic [LCNT_W-1:0] lcnt;

    // Counting one past the fire value and parking there limits it to one pulse per press.
    assign long_fire = btn_held && btn_s && (lcnt == LCNT_FIRE);

    always_ff @(posedge clk) begin
        if (!rst || !btn_held) begin
            lcnt <= '0;
        end else if (btn_s && lcnt != LCNT_SAT) begin
            lcnt <= lcnt + LCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            long_press <= 1'b0;
        end else begin
            long_press <= long_fire;
        end
    end
`else
    assign long_fire  = 1'b0;
    assign long_press = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode     <= MODE_0;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= press_acc || long_fire;
            if (long_fire) begin
                mode <= MODE_0;
            end else if (press_acc) begin
                mode <= next_mode(mode, NUM_MODES);
            end
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: a 4-mode and a 3-mode instance share one button;
// expectations come from a per-edge behavioural model plus fixed scenario values.
module tb_led_mode_ctrl;

    localparam int D = 4;
    localparam int L = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       btn_in = 1'b1;
    logic [1:0] mode4, mode3;
    logic       chg4, chg3, held4, held3, lp4, lp3;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    led_mode_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_MODES(4), .LONG_PRESS_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .mode(mode4), .mode_chg(chg4), .btn_held(held4), .long_press(lp4)
    );

    led_mode_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_MODES(3), .LONG_PRESS_CYCLES(L)) dut3 (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .mode(mode3), .mode_chg(chg3), .btn_held(held3), .long_press(lp3)
    );

    // Reference: the button level seen by the debouncer lags btn_in by two edges; the
    // debounced level flips once D consecutive samples disagree with it.
    bit         m_s1, m_s2, m_lvl, m_chg, m_lpp;
    int         m_streak, m_lp;
    logic [1:0] m_mode4, m_mode3;

    always @(posedge clk) begin
        bit bs;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_chg = 0; m_lpp = 0;
            m_streak = 0; m_lp = 0; m_mode4 = 2'd0; m_mode3 = 2'd0;
        end else begin
            bs = m_s2; m_s2 = m_s1; m_s1 = btn_in;
            m_chg = 0; m_lpp = 0;
            m_streak = (bs != m_lvl) ? m_streak + 1 : 0;
            if (m_streak == D) begin
                m_lvl = bs;
                m_streak = 0;
                if (bs) begin
                    m_mode4 = (m_mode4 == 2'd3) ? 2'd0 : m_mode4 + 2'd1;
                    m_mode3 = (m_mode3 == 2'd2) ? 2'd0 : m_mode3 + 2'd1;
                    m_chg = 1;
                    m_lp = 0;
                end
            end else if (m_lvl && bs) begin
                m_lp++;
`ifdef LED_MODE_LONG_PRESS_EN
                if (m_lp == L) begin
                    m_mode4 = 2'd0; m_mode3 = 2'd0; m_chg = 1; m_lpp = 1;
                end
`endif
            end
        end
    end

    logic [9:0] got, exp_v;
    assign got   = {mode4, chg4, held4, lp4, mode3, chg3, held3, lp3};
    assign exp_v = {m_mode4, m_chg, m_lvl, m_lpp, m_mode3, m_chg, m_lvl, m_lpp};

    task automatic test_reset();
        rst = 0; btn_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({mode4, chg4, held4, mode3, chg3, held3} !== 8'b0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b expected 00000000", i,
                         {mode4, chg4, held4, mode3, chg3, held3});
            end
        end
        rst = 1; btn_in = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] e;
        for (int j = 0; j < 30; j++) begin
            btn_in = (j < 20);
            @(negedge clk);
            e = {(j >= 5) ? 2'd1 : 2'd0, (j == 5), (j >= 5 && j < 25)};
            n_tests++;
            if ({mode4, chg4, held4} !== e || {mode3, chg3, held3} !== e) begin
                n_fail++;
                $display("FAIL clean_press cyc %0d: got %b/%b expected %b", j,
                         {mode4, chg4, held4}, {mode3, chg3, held3}, e);
            end
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL clean_press_model cyc %0d: got %b expected %b", j, got, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        for (int j = 0; j < 48; j++) begin
            btn_in = (j < 40) && (j % 4 != 3);
            @(negedge clk);
            n_tests++;
            if ({mode4, chg4, held4, mode3, chg3, held3} !== 8'b0 || got !== exp_v) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: got %b expected %b (mode 0, no change)", j, got, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] w4 [4];
        logic [1:0] w3 [4];
        int p4, p3;
        w4 = '{2'd1, 2'd2, 2'd3, 2'd0};
        w3 = '{2'd1, 2'd2, 2'd0, 2'd1};
        for (int p = 0; p < 4; p++) begin
            p4 = 0; p3 = 0;
            for (int j = 0; j < 16; j++) begin
                btn_in = (j < 8);
                @(negedge clk);
                if (chg4) p4++;
                if (chg3) p3++;
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL wrap_model press %0d cyc %0d: got %b expected %b", p, j, got, exp_v);
                end
            end
            n_tests++;
            if (mode4 !== w4[p] || mode3 !== w3[p] || p4 != 1 || p3 != 1) begin
                n_fail++;
                $display("FAIL wrap press %0d: modes %0d/%0d pulses %0d/%0d expected %0d/%0d pulses 1/1",
                         p, mode4, mode3, p4, p3, w4[p], w3[p]);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        btn_in = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL mid_press_pre cyc %0d: got %b expected %b", j, got, exp_v);
            end
        end
        rst = 0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            n_tests++;
            if ({mode4, chg4, held4, mode3, chg3, held3} !== 8'b0) begin
                n_fail++;
                $display("FAIL mid_press_rst cyc %0d: got %b expected 00000000", j,
                         {mode4, chg4, held4, mode3, chg3, held3});
            end
        end
        rst = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (mode4 !== ((i >= 5) ? 2'd1 : 2'd0) || mode3 !== ((i >= 5) ? 2'd1 : 2'd0)
                || chg4 !== (i == 5) || got !== exp_v) begin
                n_fail++;
                $display("FAIL mid_press_after edge %0d: got %b expected %b", i + 1, got, exp_v);
            end
        end
        btn_in = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_long_press();
        logic [1:0] e_m;
        logic       e_lp;
        int         n_lp;
        for (int j = 0; j < 16; j++) begin
            btn_in = (j < 8);
            @(negedge clk);
        end
        n_tests++;
        if (mode4 !== 2'd2) begin
            n_fail++;
            $display("FAIL long_setup: mode %0d expected 2", mode4);
        end
        n_lp = 0;
        for (int j = 0; j < 50; j++) begin
            btn_in = (j < 40);
            @(negedge clk);
`ifdef LED_MODE_LONG_PRESS_EN
            e_m  = (j < 5) ? 2'd2 : (j < 21) ? 2'd3 : 2'd0;
            e_lp = (j == 21);
`else
            e_m  = (j < 5) ? 2'd2 : 2'd3;
            e_lp = 1'b0;
`endif
            if (lp4) n_lp++;
            n_tests++;
            if (mode4 !== e_m || lp4 !== e_lp || lp3 !== e_lp || got !== exp_v) begin
                n_fail++;
                $display("FAIL long_press cyc %0d: mode %0d lp %b expected mode %0d lp %b (vec %b vs %b)",
                         j, mode4, lp4, e_m, e_lp, got, exp_v);
            end
        end
        n_tests++;
`ifdef LED_MODE_LONG_PRESS_EN
        if (n_lp != 1) begin
`else
        if (n_lp != 0) begin
`endif
            n_fail++;
            $display("FAIL long_press_count: got %0d pulses", n_lp);
        end
    endtask

    task automatic test_random();
        int  len;
        bit  lvl;
        for (int r = 0; r < 80; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 7));
            if ($urandom_range(0, 19) == 0) rst = 0;
            for (int i = 0; i < len; i++) begin
                btn_in = lvl;
                @(negedge clk);
                rst = 1;
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL random run %0d cyc %0d: got %b expected %b", r, i, got, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_reset_mid_press();
        test_long_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
